// File: rtl/slow_tick_pkg.sv
// Shared types and default constants for the slow-tick countdown timer.
package slow_tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          CNT_W_DEFAULT     = 6;
    localparam int unsigned STALL_MAX_DEFAULT = 26'd60000000;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes the divider's slow clock into the fast domain and produces a
// registered one-cycle rising-edge pulse plus a raw any-edge indication.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_toggle
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= w_level;
            r_rise <= w_level & ~r_prev;
        end
    end

    assign o_rise   = r_rise;
    assign o_toggle = w_level ^ r_prev;

endmodule

// File: rtl/slow_tick_timer.sv
// Converts slow_clk rising edges into fast-domain ticks and counts them down.
// Optional stall detection is built when SLOW_TICK_STALL_DETECT_EN is defined.
module slow_tick_timer
    import slow_tick_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int          CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned STALL_MAX   = STALL_MAX_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             slow_clk,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    input  logic             abort,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             expired,
    output logic             stall
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_busy;
    logic               r_expired;
    logic               w_tick;
    logic               w_toggle;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_async  (slow_clk),
        .o_rise   (w_tick),
        .o_toggle (w_toggle)
    );

    // Priority is abort, then start, then tick; a start coincident with a tick reloads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_expired   <= 1'b0;
        end else if (abort && (r_state != ST_IDLE)) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_expired   <= 1'b0;
        end else if (start) begin
            if (load_val != '0) begin
                r_state     <= ST_RUN;
                r_remaining <= load_val;
                r_busy      <= 1'b1;
                r_expired   <= 1'b0;
            end else begin
                r_state     <= ST_DONE;
                r_remaining <= '0;
                r_busy      <= 1'b0;
                r_expired   <= 1'b1;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_tick) begin
                        if (r_remaining <= CNT_W'(1)) begin
                            r_state     <= ST_DONE;
                            r_remaining <= '0;
                            r_busy      <= 1'b0;
                            r_expired   <= 1'b1;
                        end else begin
                            r_remaining <= r_remaining - CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_expired <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tick      = w_tick;
    assign busy      = r_busy;
    assign remaining = r_remaining;
    assign expired   = r_expired;

`ifdef SLOW_TICK_STALL_DETECT_EN
    localparam int unsigned AGE_W = $clog2(STALL_MAX + 1);

    logic [AGE_W-1:0] r_age;

    // Cycles since the last synchronized edge of either polarity, saturating.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_age <= '0;
        end else if (w_toggle) begin
            r_age <= '0;
        end else if (r_age != AGE_W'(STALL_MAX)) begin
            r_age <= r_age + AGE_W'(1);
        end
    end

    assign stall = (r_age == AGE_W'(STALL_MAX));
`else
    // Without the age counter stall is constant; the terms keep the inputs referenced.
    assign stall = 1'b0 & w_toggle & (STALL_MAX != 0);
`endif

endmodule

// File: tb/tb_slow_tick_timer.sv
// Directed self-checking bench for slow_tick_timer (SYNC_STAGES=2, CNT_W=6, STALL_MAX=20).
module tb_slow_tick_timer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       slow_clk;
    logic       start;
    logic [5:0] load_val;
    logic       abort;
    logic       tick;
    logic       busy;
    logic [5:0] remaining;
    logic       expired;
    logic       stall;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    slow_tick_timer #(
        .SYNC_STAGES(2),
        .CNT_W      (6),
        .STALL_MAX  (20)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .slow_clk (slow_clk),
        .start    (start),
        .load_val (load_val),
        .abort    (abort),
        .tick     (tick),
        .busy     (busy),
        .remaining(remaining),
        .expired  (expired),
        .stall    (stall)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Raises slow_clk and returns just after the edge on which tick is high.
    task automatic tick_pulse();
        slow_clk = 1'b1;
        step();
        step();
        step();
        slow_clk = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        #2;
        checks++; if (tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick: got %0b expected 0", tick); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (remaining !== 6'd0) begin errors++; $display("[TB] FAIL reset_remaining: got %0d expected 0", remaining); end
        checks++; if (expired !== 1'b0) begin errors++; $display("[TB] FAIL reset_expired: got %0b expected 0", expired); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall); end
        step();
        step();
        @(negedge clock);
        reset_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_tick_generation();
        int nticks;
        logic exp_tick;
        nticks = 0;
        for (int c = 0; c < 40; c++) begin
            slow_clk = ((c % 20) >= 10);
            step();
            exp_tick = ((c % 20) == 12);
            if (tick === 1'b1) nticks++;
            checks++;
            if (tick !== exp_tick) begin
                errors++;
                $display("[TB] FAIL tick_gen cycle %0d: got %0b expected %0b", c, tick, exp_tick);
            end
        end
        checks++;
        if (nticks != 2) begin errors++; $display("[TB] FAIL tick_count: got %0d expected 2", nticks); end
        slow_clk = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_countdown();
        logic [5:0] exp_rem;
        start = 1'b1;
        load_val = 6'd3;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL cd_busy_start: got %0b expected 1", busy); end
        checks++; if (remaining !== 6'd3) begin errors++; $display("[TB] FAIL cd_load: got %0d expected 3", remaining); end
        for (int k = 2; k >= 0; k--) begin
            tick_pulse();
            checks++; if (tick !== 1'b1) begin errors++; $display("[TB] FAIL cd_tick_%0d: got %0b expected 1", k, tick); end
            step();
            exp_rem = 6'(k);
            checks++;
            if (remaining !== exp_rem) begin errors++; $display("[TB] FAIL cd_remaining_%0d: got %0d expected %0d", k, remaining, exp_rem); end
            checks++;
            if (expired !== (k == 0)) begin errors++; $display("[TB] FAIL cd_expired_%0d: got %0b expected %0b", k, expired, (k == 0)); end
            checks++;
            if (busy !== (k != 0)) begin errors++; $display("[TB] FAIL cd_busy_%0d: got %0b expected %0b", k, busy, (k != 0)); end
        end
        step();
        checks++; if (expired !== 1'b0) begin errors++; $display("[TB] FAIL cd_expired_one_cycle: got %0b expected 0", expired); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cd_busy_after: got %0b expected 0", busy); end
        step();
    endtask

    task automatic test_zero_load();
        start = 1'b1;
        load_val = 6'd0;
        step();
        start = 1'b0;
        checks++; if (expired !== 1'b1) begin errors++; $display("[TB] FAIL zero_expired: got %0b expected 1", expired); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy: got %0b expected 0", busy); end
        checks++; if (remaining !== 6'd0) begin errors++; $display("[TB] FAIL zero_remaining: got %0d expected 0", remaining); end
        step();
        checks++; if (expired !== 1'b0) begin errors++; $display("[TB] FAIL zero_expired_drop: got %0b expected 0", expired); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy_after: got %0b expected 0", busy); end
    endtask

    task automatic test_abort_vs_tick();
        start = 1'b1;
        load_val = 6'd2;
        step();
        start = 1'b0;
        tick_pulse();
        step();
        checks++; if (remaining !== 6'd1) begin errors++; $display("[TB] FAIL abort_pre_rem: got %0d expected 1", remaining); end
        tick_pulse();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %0b expected 0", busy); end
        checks++; if (remaining !== 6'd0) begin errors++; $display("[TB] FAIL abort_remaining: got %0d expected 0", remaining); end
        checks++; if (expired !== 1'b0) begin errors++; $display("[TB] FAIL abort_expired: got %0b expected 0", expired); end
        step();
        checks++; if (expired !== 1'b0) begin errors++; $display("[TB] FAIL abort_expired_late: got %0b expected 0", expired); end
        step();
    endtask

    task automatic test_start_vs_tick();
        start = 1'b1;
        load_val = 6'd5;
        step();
        start = 1'b0;
        tick_pulse();
        start = 1'b1;
        load_val = 6'd7;
        step();
        start = 1'b0;
        checks++; if (remaining !== 6'd7) begin errors++; $display("[TB] FAIL reload_remaining: got %0d expected 7", remaining); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reload_busy: got %0b expected 1", busy); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reload_abort_busy: got %0b expected 0", busy); end
        step();
    endtask

    task automatic test_reset_mid_count();
        start = 1'b1;
        load_val = 6'd6;
        step();
        start = 1'b0;
        tick_pulse();
        step();
        tick_pulse();
        step();
        checks++; if (remaining !== 6'd4) begin errors++; $display("[TB] FAIL midrst_pre_rem: got %0d expected 4", remaining); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %0b expected 0", busy); end
        checks++; if (remaining !== 6'd0) begin errors++; $display("[TB] FAIL midrst_remaining: got %0d expected 0", remaining); end
        checks++; if (expired !== 1'b0) begin errors++; $display("[TB] FAIL midrst_expired: got %0b expected 0", expired); end
        checks++; if (tick !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tick: got %0b expected 0", tick); end
        step();
        @(negedge clock);
        reset_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy_after: got %0b expected 0", busy); end
        checks++; if (expired !== 1'b0) begin errors++; $display("[TB] FAIL midrst_expired_after: got %0b expected 0", expired); end
    endtask

    task automatic test_stall();
`ifdef SLOW_TICK_STALL_DETECT_EN
        slow_clk = 1'b0;
        repeat (25) step();
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_held: got %0b expected 1", stall); end
        slow_clk = 1'b1;
        repeat (3) step();
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_cleared_rise: got %0b expected 0", stall); end
        repeat (19) step();
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_before_max: got %0b expected 0", stall); end
        step();
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_at_max: got %0b expected 1", stall); end
        slow_clk = 1'b0;
        repeat (3) step();
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_cleared_fall: got %0b expected 0", stall); end
`else
        slow_clk = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            checks++;
            if (stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_off cycle %0d: got %0b expected 0", c, stall); end
        end
`endif
    endtask

    initial begin
        slow_clk = 1'b0;
        start    = 1'b0;
        load_val = 6'd0;
        abort    = 1'b0;
        test_reset();
        test_tick_generation();
        test_countdown();
        test_zero_load();
        test_abort_vs_tick();
        test_start_vs_tick();
        test_reset_mid_count();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slow_tick_timer.md
# slow_tick_timer

Consumes the toggling slow clock produced by the 2 Hz clock divider as a data signal in the fast system-clock domain, converting each of its rising edges into a single-cycle `tick` strobe. A load/countdown FSM counts those ticks to time game events such as a mole's visible window, and reports expiry. It sits between the clock divider and the game-control logic, so no logic outside the divider is ever clocked by the slow signal.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `slow_clk`; legal values are 2 or more.
- `CNT_W`, 6: width of the countdown value.
- `STALL_MAX`, 26'd60000000: fast-clock cycles without a `slow_clk` edge before `stall` asserts.
- `clock`  in  1: system clock, the only clock.
- `reset_n`  in  1: one clock; reset is asynchronous and active-low.
- `slow_clk`  in  1: divider output, asynchronous to this block's sampling.
- `start`  in  1: load `load_val` and begin the countdown.
- `load_val`  in  CNT_W: number of ticks to count.
- `abort`  in  1: cancel the countdown without expiry.
- `tick`  out  1: one-cycle pulse per `slow_clk` rising edge.
- `busy`  out  1: high while in RUN.
- `remaining`  out  CNT_W: ticks left.
- `expired`  out  1: one-cycle pulse when the countdown completes.
- `stall`  out  1: `slow_clk` has stopped toggling.

## Operation
- `slow_clk` passes through a `SYNC_STAGES`-flop synchronizer. The last stage is compared against a `prev` register to detect edges.
- `tick` is registered and equals synchronized-high AND `prev`-low. A level held high yields exactly one tick.
- FSM states are IDLE, RUN and DONE. `busy` = (state==RUN). `expired` = (state==DONE).
- **IDLE:**
  - `start` with `load_val` != 0: go to RUN, `remaining` <= `load_val`.
  - `start` with `load_val` == 0: go to DONE, `remaining` <= 0.
- **RUN:**
  - `tick` decrements `remaining`.
  - `tick` with `remaining` == 1: `remaining` <= 0, go to DONE.
- **DONE:** lasts exactly one cycle, then returns to IDLE. `start` during DONE is accepted with the same rules as IDLE.
- **Event priority:** `abort` > `start` > `tick`.
  - `abort` in RUN or DONE: go to IDLE, `remaining` <= 0, no `expired` pulse.
  - `start` in RUN reloads the count; a coincident tick is discarded.
- `abort` in IDLE has no effect.
- Arithmetic is unsigned `CNT_W`-bit. `remaining` never wraps, because decrement only happens from values of 1 or more.

## Timing
- **Reset values:** all synchronizer flops, `prev`, `tick`, `busy`, `expired`, `stall` = 0; `remaining` = 0; state = IDLE.
- **Tick latency:** `tick` goes high on the (`SYNC_STAGES`+1)th `clock` edge after the first edge that samples `slow_clk` high.
- **Countdown latency:** `remaining` updates and the state changes on the edge after `tick` is high.
  - `expired` is high for the cycle that follows the final tick.
  - `busy` drops on the same edge that `expired` rises.
- **`start` latency:** `busy` rises the cycle after `start`.
- **Reset mid-count:** asserting reset mid-count returns the block to reset values immediately; no `expired` pulse is produced.

## Configuration
- **`SLOW_TICK_STALL_DETECT_EN` defined:**
  - An edge-age counter counts `clock` cycles since the last edge (either polarity) of the synchronized `slow_clk`, saturating at `STALL_MAX`.
  - `stall` = 1 while the counter equals `STALL_MAX`.
  - Any edge clears the counter and `stall` on the next cycle.
- **Macro undefined:** `stall` is tied to 0 and no counter is built.

## Structure
- Package `slow_tick_pkg` holds:
  - the FSM state typedef (IDLE/RUN/DONE);
  - the default `CNT_W` constant;
  - the default `STALL_MAX` constant.
- Sub-module `sync_edge_detect`: the synchronizer, `prev` register and registered rising-edge pulse, parameterised by `SYNC_STAGES`. The top level instantiates it once.

## Test plan
- **Tick generation:** toggle `slow_clk` every 10 cycles → one `tick` per rising edge, 3 cycles after sampling high with `SYNC_STAGES`=2, and none on falling edges.
- **Countdown:** `start` with `load_val`=3 → `busy` high; `remaining` goes 3→2→1→0 on successive ticks; one `expired` pulse; `busy` low on that same cycle.
- **Zero load:** `start` with `load_val`=0 → `expired` high the next cycle; `busy` never rises.
- **Abort vs tick:** `abort` coincident with the tick at `remaining`=1 → IDLE, `remaining`=0, no `expired`. `start` coincident with a tick in RUN → `remaining` = new `load_val`, not decremented.
- **Reset mid-count:** assert `reset_n`=0 while `remaining`=4 → all outputs 0 asynchronously, state IDLE.
- **Stall (macro on, `STALL_MAX`=20):** hold `slow_clk` constant → `stall` rises after 20 cycles without an edge; a subsequent edge clears it. With the macro off, `stall` stays 0.
